// File: rtl/mxint_exp_sched.sv
// Round-robin front end sharing one fixed-latency MXINT exp unit between NUM_REQ
// streams; results are tagged with the requester ID and parked in a credit-protected FIFO.
module mxint_exp_sched #(
  parameter int NUM_REQ       = 4,
  parameter int BLOCK_SIZE    = 16,
  parameter int MAN_IN_WIDTH  = 8,
  parameter int EXP_IN_WIDTH  = 3,
  parameter int MAN_OUT_WIDTH = 10,
  parameter int EXP_OUT_WIDTH = 4,
  parameter int EXP_LATENCY   = 1,
  parameter int FIFO_DEPTH    = 4,
  parameter int ID_W          = $clog2(NUM_REQ)
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [NUM_REQ*BLOCK_SIZE*MAN_IN_WIDTH-1:0]    req_mdata,
  input  logic [NUM_REQ*EXP_IN_WIDTH-1:0]               req_edata,
  input  logic [NUM_REQ-1:0]                            req_valid,
  output logic [NUM_REQ-1:0]                            req_ready,
  output logic [BLOCK_SIZE*MAN_IN_WIDTH-1:0]            exp_mdata_in,
  output logic [EXP_IN_WIDTH-1:0]                       exp_edata_in,
  output logic                                          exp_in_valid,
  input  logic                                          exp_in_ready,
  output logic                                          exp_out_ready,
  input  logic [BLOCK_SIZE*MAN_OUT_WIDTH-1:0]           exp_mdata_out,
  input  logic [BLOCK_SIZE*EXP_OUT_WIDTH-1:0]           exp_edata_out,
  input  logic                                          exp_out_valid,
  output logic [BLOCK_SIZE*MAN_OUT_WIDTH-1:0]           out_mdata,
  output logic [BLOCK_SIZE*EXP_OUT_WIDTH-1:0]           out_edata,
  output logic [ID_W-1:0]                               out_id,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]               fifo_count,
  output logic                                          tag_err
);

  localparam int MB    = BLOCK_SIZE * MAN_IN_WIDTH;
  localparam int OMB   = BLOCK_SIZE * MAN_OUT_WIDTH;
  localparam int OEB   = BLOCK_SIZE * EXP_OUT_WIDTH;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int INF_W = $clog2(EXP_LATENCY + 1);

  logic [ID_W-1:0]  rr_q, rr_d;
  logic [ID_W-1:0]  grant, cand;
  logic             found;
  logic [INF_W-1:0] inflight;
  logic             credit_ok, issue;

  logic [EXP_LATENCY-1:0] tag_v_q;
  logic [ID_W-1:0]        tag_id_q [EXP_LATENCY];
  logic                   tail_v;
  logic [ID_W-1:0]        tail_id;

  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             err_q, err_d;
  logic             full, push, pop;
  logic [OMB-1:0]   mem_m  [FIFO_DEPTH];
  logic [OEB-1:0]   mem_e  [FIFO_DEPTH];
  logic [ID_W-1:0]  mem_id [FIFO_DEPTH];

  // First valid requester at or after rr_q, wrapping; falls back to rr_q when none.
  always_comb begin
    grant = rr_q;
    cand  = rr_q;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((int'(rr_q) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        grant = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    inflight = '0;
    for (int s = 0; s < EXP_LATENCY; s++) inflight = inflight + INF_W'(tag_v_q[s]);
  end

  // Credit counts blocks still inside the exp unit, so the unit never needs to stall.
  assign credit_ok = (int'(count_q) + int'(inflight)) < FIFO_DEPTH;
  assign issue     = (|req_valid) && exp_in_ready && credit_ok && !rst;

  assign req_ready     = issue ? (NUM_REQ'(1) << grant) : '0;
  assign exp_in_valid  = issue;
  assign exp_mdata_in  = req_mdata[grant*MB +: MB];
  assign exp_edata_in  = req_edata[grant*EXP_IN_WIDTH +: EXP_IN_WIDTH];
  assign exp_out_ready = 1'b1;
  assign rr_d          = issue ? ID_W'((int'(grant) + 1) % NUM_REQ) : rr_q;

  assign tail_v  = tag_v_q[EXP_LATENCY-1];
  assign tail_id = tail_v ? tag_id_q[EXP_LATENCY-1] : '0;

  assign full = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop  = (count_q != '0) && out_ready;
  assign push = exp_out_valid && !full;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    err_d    = err_q | (exp_out_valid != tail_v) | (exp_out_valid && full);
    if (push) wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH-1)) ? '0 : wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH-1)) ? '0 : rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q     <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= 1'b0;
      tag_v_q  <= '0;
      for (int s = 0; s < EXP_LATENCY; s++) tag_id_q[s] <= '0;
      for (int d = 0; d < FIFO_DEPTH; d++) mem_id[d] <= '0;
    end else begin
      rr_q        <= rr_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      err_q       <= err_d;
      tag_v_q[0]  <= issue;
      tag_id_q[0] <= grant;
      for (int s = 1; s < EXP_LATENCY; s++) begin
        tag_v_q[s]  <= tag_v_q[s-1];
        tag_id_q[s] <= tag_id_q[s-1];
      end
      if (push) mem_id[wr_ptr_q] <= tail_id;
    end
  end

  // Payload storage carries no reset; out_valid qualifies it.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_m[wr_ptr_q] <= exp_mdata_out;
      mem_e[wr_ptr_q] <= exp_edata_out;
    end
  end

  assign out_mdata  = mem_m[rd_ptr_q];
  assign out_edata  = mem_e[rd_ptr_q];
  assign out_id     = mem_id[rd_ptr_q];
  assign out_valid  = (count_q != '0);
  assign fifo_count = count_q;
  assign tag_err    = err_q;

endmodule

// File: doc/mxint_exp_sched.md
# mxint_exp_sched

Round-robin scheduler that shares one MXINT exponential unit between `NUM_REQ` requester streams, e.g. attention heads or softmax row engines. It arbitrates block-level requests and issues one block per cycle into the exp unit. It tracks in-flight blocks with a tag pipeline matched to the unit's fixed latency. Results land in a credit-protected output FIFO tagged with the requester ID, because the exp unit cannot stall once a block is issued.

## Interface
- `NUM_REQ`, 4, number of requesters (≥2)
- `BLOCK_SIZE`, 16, mantissas per MXINT block
- `MAN_IN_WIDTH`, 8, input mantissa width
- `EXP_IN_WIDTH`, 3, input shared-exponent width
- `MAN_OUT_WIDTH`, 10, result mantissa width
- `EXP_OUT_WIDTH`, 4, result per-element exponent width
- `EXP_LATENCY`, 1, exp unit input-to-output latency in cycles (≥1)
- `FIFO_DEPTH`, 4, output FIFO entries (≥2)
- `ID_W`, `$clog2(NUM_REQ)`, requester-ID width (derived)

Ports:
- `clk` in 1: clock
- `rst` in 1: reset, synchronous, active-high
- `req_mdata` in [NUM_REQ][BLOCK_SIZE]×MAN_IN_WIDTH: request mantissas
- `req_edata` in [NUM_REQ]×EXP_IN_WIDTH: request shared exponents
- `req_valid` in NUM_REQ: per-requester valid
- `req_ready` out NUM_REQ: per-requester accept (one-hot or zero)
- `exp_mdata_in` out [BLOCK_SIZE]×MAN_IN_WIDTH: to exp unit
- `exp_edata_in` out EXP_IN_WIDTH: to exp unit
- `exp_in_valid` out 1: issue strobe
- `exp_in_ready` in 1: exp unit ready
- `exp_out_ready` out 1: constant 1
- `exp_mdata_out` in [BLOCK_SIZE]×MAN_OUT_WIDTH: from exp unit
- `exp_edata_out` in [BLOCK_SIZE]×EXP_OUT_WIDTH: from exp unit
- `exp_out_valid` in 1: exp result valid
- `out_mdata` out [BLOCK_SIZE]×MAN_OUT_WIDTH: FIFO head mantissas
- `out_edata` out [BLOCK_SIZE]×EXP_OUT_WIDTH: FIFO head exponents
- `out_id` out ID_W: originating requester
- `out_valid` out 1: FIFO non-empty
- `out_ready` in 1: downstream accept
- `fifo_count` out $clog2(FIFO_DEPTH+1): FIFO occupancy
- `tag_err` out 1: sticky tag/valid mismatch flag

## Operation
- Credit: `credit_ok = fifo_count + inflight < FIFO_DEPTH`, where `inflight` is the popcount of tag-pipe valid bits. A pop in the same cycle does not free credit.
- Issue condition: `|req_valid && exp_in_ready && credit_ok`.
- Grant: the lowest index ≥ `rr_ptr` with `req_valid` set, wrapping modulo `NUM_REQ`.
  - `req_ready[g]=1` only on an issue cycle; all bits are 0 otherwise.
  - After an issue, `rr_ptr <= (g+1) mod NUM_REQ`. With no issue, `rr_ptr` holds.
- Exp mux: `exp_mdata_in`/`exp_edata_in` select the granted requester; they select `rr_ptr` when idle (don't-care). `exp_in_valid` equals the issue condition.
- Tag pipe: `EXP_LATENCY` stages of {valid, id}. Stage 0 is loaded with {issue, g}, and stages shift every cycle.
- Capture: when `exp_out_valid`=1, push {exp_mdata_out, exp_edata_out, tail-stage id} into the FIFO.
  - If `exp_out_valid` differs from the tail-stage valid, set `tag_err`. It clears only on `rst`.
  - A push with a tail valid of 0 still writes, using id 0.
- FIFO: circular buffer with `FIFO_DEPTH` entries and registered head outputs. Pop when `out_valid && out_ready`.
  - Simultaneous push and pop leaves the count unchanged.
  - Push into a full FIFO cannot occur by construction. If it does anyway, drop the data and set `tag_err`.
- Combinational paths: `req_ready`, `exp_in_valid` and the exp mux are combinational from `req_valid`, `exp_in_ready`, `rr_ptr` and the count/inflight registers. There is no path from `out_ready` to `req_ready`.

## Timing
- Reset values: `req_ready`=0, `exp_in_valid`=0, `out_valid`=0, `out_id`=0, `fifo_count`=0, `tag_err`=0, `rr_ptr`=0, tag pipe cleared. `exp_out_ready`=1 always.
- Reset mid-operation flushes the FIFO and the tag pipe.
  - The exp unit's valid also resets, so nothing arrives afterward.
  - Any `exp_out_valid` seen during `rst` is ignored.
- Latency: a request accepted at cycle t shows `out_valid` at t+EXP_LATENCY+1, with out_ready held high.
- Throughput: one block per cycle when `FIFO_DEPTH ≥ EXP_LATENCY+2` and `out_ready` is held high.
- Backpressure: with `out_ready`=0, at most `FIFO_DEPTH` blocks are issued, then `req_ready` holds 0. Issue resumes the cycle after the first pop is registered.

## Test plan
- Single request: requester 2 valid at cycle 5, `exp_in_ready`=1, `out_ready`=1 → `req_ready`=4'b0100 at cycle 5; `out_valid`=1 with `out_id`=2 at cycle 7 (EXP_LATENCY=1); payload equals the exp unit output.
- Fairness: all 4 requesters valid continuously for 8 cycles → grant order 0,1,2,3,0,1,2,3; `out_id` sequence matches; no bubbles.
- Backpressure: all valid, `out_ready`=0 → exactly 4 issues, then `req_ready`=0 and `fifo_count`=4. Raise `out_ready` → 4 pops in order, and issue restarts at requester 0 after its pop.
- `exp_in_ready`=0 for 3 cycles while requester 1 is valid → no issue and `rr_ptr` unchanged; requester 1 is granted on the first ready cycle.
- Reset mid-stream: `rst` asserted with 1 block in flight and 2 in the FIFO → next cycle `out_valid`=0, `fifo_count`=0, `tag_err`=0, and the first grant after reset goes to requester 0.
- Mismatch: inject `exp_out_valid`=1 with an empty tag pipe → `tag_err`=1 and stays set until `rst`.
